// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, run/lap/pause FSM,
// millisecond count-enable prescaler and lap-freeze display path.
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned TICK_HZ    = 1000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    input  logic [11:0] milli_i,
    input  logic [7:0]  seconds_i,
    input  logic [7:0]  minutes_i,
    input  logic [7:0]  hours_i,
    output logic        count_en,
    output logic        count_clr,
    output logic [11:0] milli_o,
    output logic [7:0]  seconds_o,
    output logic [7:0]  minutes_o,
    output logic [7:0]  hours_o,
    output logic [1:0]  state_o,
    output logic        lap_active
);

    localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int unsigned NBTN = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_LAP   = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    state_t            r_state;
    logic [NBTN-1:0]   r_sync1;
    logic [NBTN-1:0]   r_sync2;
    logic [NBTN-1:0]   r_deb;
    logic [NBTN-1:0]   r_deb_d;
    logic [DW-1:0]     r_deb_cnt [NBTN];
    logic [PW-1:0]     r_presc;
    logic              r_count_en;
    logic              r_count_clr;
    logic              r_lap_active;
    logic [11:0]       r_snap_milli;
    logic [7:0]        r_snap_sec;
    logic [7:0]        r_snap_min;
    logic [7:0]        r_snap_hr;
    logic [11:0]       r_milli_o;
    logic [7:0]        r_sec_o;
    logic [7:0]        r_min_o;
    logic [7:0]        r_hr_o;

    logic [NBTN-1:0]   w_btn_raw;
    logic [NBTN-1:0]   w_press;
    logic              w_clr;
    logic              w_ss;
    logic              w_lap;
    logic              w_running;
    logic              w_tick;

    // Bit order: 0 = start/stop, 1 = lap, 2 = clear
    assign w_btn_raw = {btn_clear, btn_lap, btn_start_stop};
    assign w_press   = r_deb & ~r_deb_d;

    // Same-cycle priority: clear, then start/stop, then lap; losers are dropped
    assign w_clr = w_press[2];
    assign w_ss  = w_press[0] & ~w_press[2];
    assign w_lap = w_press[1] & ~w_press[2] & ~w_press[0];

    assign w_running = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick    = (r_presc == PW'(DIV - 1));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb_d <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
        end
    end

    // Level changes only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_deb <= '0;
            for (int i = 0; i < int'(NBTN); i++) r_deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NBTN); i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                        r_deb[i]     <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lap_active <= 1'b0;
            r_count_clr  <= 1'b0;
            r_snap_milli <= '0;
            r_snap_sec   <= '0;
            r_snap_min   <= '0;
            r_snap_hr    <= '0;
        end else begin
            r_count_clr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_clr) begin
                        r_count_clr <= 1'b1;
                    end else if (w_ss) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_ss) begin
                        r_state <= S_PAUSE;
                    end else if (w_lap) begin
                        r_state      <= S_LAP;
                        r_lap_active <= 1'b1;
                        r_snap_milli <= milli_i;
                        r_snap_sec   <= seconds_i;
                        r_snap_min   <= minutes_i;
                        r_snap_hr    <= hours_i;
                    end
                end
                S_LAP: begin
                    if (w_ss) begin
                        r_state      <= S_PAUSE;
                        r_lap_active <= 1'b0;
                    end else if (w_lap) begin
                        r_snap_milli <= milli_i;
                        r_snap_sec   <= seconds_i;
                        r_snap_min   <= minutes_i;
                        r_snap_hr    <= hours_i;
                    end
                end
                S_PAUSE: begin
                    if (w_clr) begin
                        r_state     <= S_IDLE;
                        r_count_clr <= 1'b1;
                    end else if (w_ss) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Prescaler holds in PAUSE so the partial millisecond survives a pause
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_count_en <= 1'b0;
        end else begin
            r_count_en <= w_running && w_tick;
            if (r_state == S_IDLE) begin
                r_presc <= '0;
            end else if (w_running) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_milli_o <= '0;
            r_sec_o   <= '0;
            r_min_o   <= '0;
            r_hr_o    <= '0;
        end else if (r_state == S_LAP) begin
            r_milli_o <= r_snap_milli;
            r_sec_o   <= r_snap_sec;
            r_min_o   <= r_snap_min;
            r_hr_o    <= r_snap_hr;
        end else begin
            r_milli_o <= milli_i;
            r_sec_o   <= seconds_i;
            r_min_o   <= minutes_i;
            r_hr_o    <= hours_i;
        end
    end

    assign count_en   = r_count_en;
    assign count_clr  = r_count_clr;
    assign milli_o    = r_milli_o;
    assign seconds_o  = r_sec_o;
    assign minutes_o  = r_min_o;
    assign hours_o    = r_hr_o;
    assign state_o    = r_state;
    assign lap_active = r_lap_active;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and a 4-cycle debounce.
module tb_stopwatch_ctrl;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_LAP   = 2'b10;
    localparam logic [1:0] ST_PAUSE = 2'b11;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        btn_start_stop;
    logic        btn_lap;
    logic        btn_clear;
    logic [11:0] milli_i;
    logic [7:0]  seconds_i;
    logic [7:0]  minutes_i;
    logic [7:0]  hours_i;
    logic        count_en;
    logic        count_clr;
    logic [11:0] milli_o;
    logic [7:0]  seconds_o;
    logic [7:0]  minutes_o;
    logic [7:0]  hours_o;
    logic [1:0]  state_o;
    logic        lap_active;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int en_cnt   = 0;
    int clr_cnt  = 0;
    int last_en  = 0;

    stopwatch_ctrl #(
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .DEB_CYCLES (4)
    ) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .milli_i        (milli_i),
        .seconds_i      (seconds_i),
        .minutes_i      (minutes_i),
        .hours_i        (hours_i),
        .count_en       (count_en),
        .count_clr      (count_clr),
        .milli_o        (milli_o),
        .seconds_o      (seconds_o),
        .minutes_o      (minutes_o),
        .hours_o        (hours_o),
        .state_o        (state_o),
        .lap_active     (lap_active)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
        if (count_en === 1'b1) begin
            en_cnt++;
            last_en = cyc;
        end
        if (count_clr === 1'b1) clr_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_state(input string tag, input logic [1:0] exp, input int max, output int lat);
        lat = 0;
        while (state_o !== exp && lat < max) begin
            tick();
            lat++;
        end
        chk(tag, 32'(state_o), 32'(exp));
    endtask

    int lat;
    int p_cyc;
    int r_cyc;
    int c_cyc;
    int n;

    initial begin
        reset = 1'b1; btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
        milli_i = '0; seconds_i = '0; minutes_i = '0; hours_i = '0;
        ticks(3);
        reset = 1'b0;

        // Reset and idle
        chk("rst_state", 32'(state_o), 32'(ST_IDLE));
        chk("rst_lap", 32'(lap_active), 0);
        en_cnt = 0;
        ticks(100);
        chk("idle_en_cnt", 32'(en_cnt), 0);
        chk("idle_state", 32'(state_o), 32'(ST_IDLE));
        chk("idle_disp", 32'({milli_o, seconds_o, minutes_o, hours_o} != 0), 0);

        // Start held 20 cycles: one pulse, then 5 count_en in 50 cycles
        btn_start_stop = 1'b1;
        wait_state("start_run", ST_RUN, 20, lat);
        chk("start_lat", 32'(lat >= 6 && lat <= 8), 1);
        ticks(20 - lat);
        btn_start_stop = 1'b0;
        en_cnt = 0;
        ticks(50);
        chk("run_en_50", 32'(en_cnt), 5);
        chk("held_one_pulse", 32'(state_o), 32'(ST_RUN));

        // Pause preserves the partial prescaler count
        ticks(3);
        btn_start_stop = 1'b1;
        wait_state("pause", ST_PAUSE, 20, lat);
        p_cyc = cyc;
        n = p_cyc - last_en;
        ticks(4);
        btn_start_stop = 1'b0;
        en_cnt = 0;
        ticks(30);
        chk("pause_no_en", 32'(en_cnt), 0);
        btn_start_stop = 1'b1;
        wait_state("resume", ST_RUN, 20, lat);
        r_cyc = cyc;
        lat = 0;
        while (count_en !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        c_cyc = cyc;
        chk("resume_en_seen", 32'(count_en), 1);
        chk("presc_held", 32'(n + (c_cyc - r_cyc)), 10);
        ticks(5);
        btn_start_stop = 1'b0;
        ticks(8);

        // Lap freeze and split
        milli_i = 12'h123; seconds_i = 8'h12; minutes_i = 8'h05; hours_i = 8'h01;
        ticks(2);
        btn_lap = 1'b1;
        wait_state("lap_enter", ST_LAP, 20, lat);
        chk("lap_active", 32'(lap_active), 1);
        milli_i = 12'h150; seconds_i = 8'h34;
        ticks(2);
        chk("lap_frozen_ms", 32'(milli_o), 32'h123);
        chk("lap_frozen_s", 32'(seconds_o), 32'h12);
        btn_lap = 1'b0;
        ticks(8);
        chk("lap_still_frozen", 32'(milli_o), 32'h123);
        milli_i = 12'h200;
        btn_lap = 1'b1;
        ticks(10);
        milli_i = 12'h210;
        ticks(2);
        chk("split_ms", 32'(milli_o), 32'h200);
        chk("split_state", 32'(state_o), 32'(ST_LAP));
        btn_lap = 1'b0;
        ticks(8);
        btn_start_stop = 1'b1;
        wait_state("lap_to_pause", ST_PAUSE, 20, lat);
        chk("pause_lap_off", 32'(lap_active), 0);
        milli_i = 12'h321;
        ticks(2);
        chk("pause_live_ms", 32'(milli_o), 32'h321);
        btn_start_stop = 1'b0;
        ticks(8);

        // Clear ignored in RUN, accepted in PAUSE
        btn_start_stop = 1'b1;
        wait_state("run_again", ST_RUN, 20, lat);
        btn_start_stop = 1'b0;
        ticks(8);
        clr_cnt = 0;
        btn_clear = 1'b1;
        ticks(10);
        btn_clear = 1'b0;
        ticks(8);
        chk("run_clr_ignored", 32'(clr_cnt), 0);
        chk("run_clr_state", 32'(state_o), 32'(ST_RUN));
        btn_start_stop = 1'b1;
        wait_state("pause2", ST_PAUSE, 20, lat);
        btn_start_stop = 1'b0;
        ticks(8);
        clr_cnt = 0;
        btn_clear = 1'b1;
        lat = 0;
        while (count_clr !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("pause_clr_seen", 32'(count_clr), 1);
        chk("pause_clr_idle", 32'(state_o), 32'(ST_IDLE));
        tick();
        chk("clr_one_cycle", 32'(count_clr), 0);
        ticks(6);
        btn_clear = 1'b0;
        ticks(8);
        chk("clr_count", 32'(clr_cnt), 1);

        // Clear and start together in PAUSE: clear wins, start dropped
        btn_start_stop = 1'b1;
        wait_state("run3", ST_RUN, 20, lat);
        btn_start_stop = 1'b0;
        ticks(8);
        btn_start_stop = 1'b1;
        wait_state("pause3", ST_PAUSE, 20, lat);
        btn_start_stop = 1'b0;
        ticks(8);
        clr_cnt = 0;
        btn_start_stop = 1'b1;
        btn_clear = 1'b1;
        ticks(15);
        chk("both_idle", 32'(state_o), 32'(ST_IDLE));
        chk("both_clr_once", 32'(clr_cnt), 1);
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
        ticks(8);

        // Lap glitches shorter than the debounce window are rejected
        btn_start_stop = 1'b1;
        wait_state("run4", ST_RUN, 20, lat);
        btn_start_stop = 1'b0;
        ticks(8);
        for (int i = 0; i < 4; i++) begin
            btn_lap = 1'b1;
            ticks(2);
            btn_lap = 1'b0;
            ticks(2);
        end
        ticks(10);
        chk("glitch_state", 32'(state_o), 32'(ST_RUN));
        chk("glitch_lap", 32'(lap_active), 0);

        // Async reset while in LAP
        milli_i = 12'h456;
        btn_lap = 1'b1;
        wait_state("lap2", ST_LAP, 20, lat);
        btn_lap = 1'b0;
        ticks(3);
        chk("lap2_frozen", 32'(milli_o), 32'h456);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_state", 32'(state_o), 32'(ST_IDLE));
        chk("arst_milli", 32'(milli_o), 0);
        chk("arst_lap", 32'(lap_active), 0);
        chk("arst_hours", 32'(hours_o), 0);
        btn_start_stop = 1'b1;
        ticks(3);
        reset = 1'b0;
        wait_state("post_rst_run", ST_RUN, 20, lat);
        chk("post_rst_lat", 32'(lat >= 6 && lat <= 8), 1);
        btn_start_stop = 1'b0;
        ticks(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
